sort_32x16b_stream_ctrl: RTL and testbench

Streaming front end and sequencer for the 32-element × 16-bit sorting network. It collects up to 32 elements from a valid/ready input stream and pads short frames. It applies the sort network once per frame and registers the result. It then replays the sorted frame on a valid/ready output stream with frame delimiting. It sits between the packet-parsing stage and any consumer needing sorted keys, and turns the combinational sorter into a flow-controlled pipeline stage.

---
 rtl/sort_32x16b_stream_ctrl_pkg.sv | 29 ++
 rtl/sort_32x16b_stream_ctrl_core.sv | 38 +++
 rtl/sort_32x16b_stream_ctrl.sv | 144 ++++++++++++++
 tb/tb_sort_32x16b_stream_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_32x16b_stream_ctrl_pkg.sv
// Shared types and constants for the 32 x 16-bit streaming sorter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sort_pkg;

  localparam int SORT_N = 32;
  localparam int SORT_W = 16;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [SORT_W-1:0] elem_t;

  // Map a drain position onto a slot of the ascending-sorted buffer.
  // Descending order reads back from the last real element (cnt-1), so
  // the padding held in slots >= cnt is never reached.
  function automatic logic [4:0] drain_slot(logic [CNT_W-1:0] rd,
                                            logic [CNT_W-1:0] cnt,
                                            logic             desc);
    logic [CNT_W-1:0] rev;
    rev = cnt - 6'd1 - rd;
    return desc ? rev[4:0] : rd[4:0];
  endfunction

endpackage

// File: rtl/sort_32x16b_stream_ctrl_core.sv
// Purely combinational ascending sorter for 32 unsigned 16-bit keys.
// Latency: 0 cycles (combinational).
// Backpressure: none; the controller samples the output while in its sort state.
// Ports: in_keys  - 32 keys, element k at bits [16k+15:16k]
//        out_keys - the same keys ascending, element 0 the smallest
module sort_32x16b_core
  import sort_pkg::*;
(
  input  logic [SORT_N*SORT_W-1:0] in_keys,
  output logic [SORT_N*SORT_W-1:0] out_keys
);

  elem_t v [SORT_N];
  elem_t t;

  // Odd-even transposition network: SORT_N alternating passes of
  // compare-exchange on neighbour pairs fully sort SORT_N elements.
  always_comb begin
    t = '0;
    for (int k = 0; k < SORT_N; k++) begin
      v[k] = in_keys[k*SORT_W +: SORT_W];
    end
    for (int p = 0; p < SORT_N; p++) begin
      for (int i = p % 2; i < SORT_N - 1; i += 2) begin
        if (v[i] > v[i+1]) begin
          t      = v[i];
          v[i]   = v[i+1];
          v[i+1] = t;
        end
      end
    end
    out_keys = '0;
    for (int k = 0; k < SORT_N; k++) begin
      out_keys[k*SORT_W +: SORT_W] = v[k];
    end
  end

endmodule

// File: rtl/sort_32x16b_stream_ctrl.sv
// Collects a frame of up to 32 keys, sorts it in one cycle, replays it sorted.
// Latency: last input handshake in cycle N -> first out_valid in N+2.
// Backpressure: in_ready low outside FILL; outputs hold while out_valid & !out_ready.
// Ports: in_valid/in_ready/in_data/in_last  - input element stream
//        out_valid/out_ready/out_data/out_last - sorted element stream
//        out_count - element count of the frame being drained, busy - SORT or DRAIN
module sort_32x16b_stream_ctrl
  import sort_pkg::*;
#(
  parameter int          DESCEND = 0,
  parameter logic [15:0] PAD_VAL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [5:0]  out_count,
  output logic        busy
);

  localparam logic DESC_B = (DESCEND != 0);

  state_t           state;
  logic [4:0]       wr_idx;
  logic [4:0]       rd_idx;
  logic [CNT_W-1:0] cnt;

  elem_t in_buf     [SORT_N];
  elem_t sorted_buf [SORT_N];
  elem_t core_elem  [SORT_N];

  logic [SORT_N*SORT_W-1:0] core_in;
  logic [SORT_N*SORT_W-1:0] core_out;

  logic             in_hs;
  logic             out_hs;
  logic [4:0]       rd_nxt;
  logic [CNT_W-1:0] rd_nxt_w;
  logic [CNT_W-1:0] cnt_m1;

  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign rd_nxt   = rd_idx + 5'd1;
  assign rd_nxt_w = {1'b0, rd_nxt};
  assign cnt_m1   = cnt - 6'd1;

  // Unused slots of a short frame sort to the top as PAD_VAL.
  always_comb begin
    core_in = '0;
    for (int k = 0; k < SORT_N; k++) begin
      core_in[k*SORT_W +: SORT_W] = (CNT_W'(k) < cnt) ? in_buf[k] : PAD_VAL;
      core_elem[k] = core_out[k*SORT_W +: SORT_W];
    end
  end

  sort_32x16b_core u_core (
    .in_keys  (core_in),
    .out_keys (core_out)
  );

  // Data buffers carry no reset: their contents only matter once written.
  always_ff @(posedge clk) begin
    if (state == FILL && in_hs) begin
      in_buf[wr_idx] <= in_data;
    end
    if (state == SORT) begin
      for (int k = 0; k < SORT_N; k++) begin
        sorted_buf[k] <= core_elem[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_idx    <= '0;
      rd_idx    <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            wr_idx <= wr_idx + 5'd1;
            // A frame closes on in_last or on its 32nd element.
            if (in_last || wr_idx == 5'd31) begin
              cnt      <= {1'b0, wr_idx} + 6'd1;
              wr_idx   <= '0;
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end

        SORT: begin
          // First output element is taken straight from the sorter so it
          // is valid in the same cycle the buffer is loaded.
          out_data  <= core_elem[drain_slot(6'd0, cnt, DESC_B)];
          out_last  <= (cnt == 6'd1);
          out_count <= cnt;
          out_valid <= 1'b1;
          rd_idx    <= '0;
          state     <= DRAIN;
        end

        DRAIN: begin
          if (out_hs) begin
            if ({1'b0, rd_idx} == cnt_m1) begin
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= sorted_buf[drain_slot(rd_nxt_w, cnt, DESC_B)];
              out_last <= (rd_nxt_w == cnt_m1);
            end
          end
        end

        default: begin
          state     <= FILL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_32x16b_stream_ctrl.sv
module tb_sort_32x16b_stream_ctrl;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic [5:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid_a = 1'b0;
  logic        in_valid_d = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [15:0] out_data_a;
  logic [5:0]  out_count_a;
  logic        in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [15:0] out_data_d;
  logic [5:0]  out_count_d;

  int tests = 0;
  int fails = 0;
  exp_t        sb [$];
  logic [15:0] frame [$];

  always #5 clk = ~clk;

  sort_32x16b_stream_ctrl #(.DESCEND(0), .PAD_VAL(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .out_count(out_count_a), .busy(busy_a)
  );

  sort_32x16b_stream_ctrl #(.DESCEND(1), .PAD_VAL(16'hFFFF)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
    .out_last(out_last_d), .out_count(out_count_d), .busy(busy_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain bubble sort of the frame, reversed for descending.
  task automatic push_exp(input bit desc);
    logic [15:0] a [$];
    logic [15:0] t;
    int n;
    a = frame;
    n = a.size();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = desc ? a[n-1-i] : a[i];
      e.l = (i == n - 1);
      e.c = 6'(n);
      sb.push_back(e);
    end
  endtask

  // Drive the frame; returns just after the posedge of the last handshake.
  task automatic send_frame(input bit sel, input bit use_last);
    push_exp(sel);
    for (int i = 0; i < frame.size(); i++) begin
      int  g;
      logic r;
      @(negedge clk);
      in_data = frame[i];
      in_last = use_last && (i == frame.size() - 1);
      if (sel) in_valid_d = 1'b1; else in_valid_a = 1'b1;
      g = 0;
      r = sel ? in_ready_d : in_ready_a;
      while (!r && g < 100) begin
        @(negedge clk);
        g++;
        r = sel ? in_ready_d : in_ready_a;
      end
      if (!r) chk("in_ready_timeout", 32'(r), 32'd1);
      @(posedge clk);
    end
    #1;
    in_valid_a = 1'b0;
    in_valid_d = 1'b0;
    in_last    = 1'b0;
  endtask

  // Accept n outputs with out_ready asserted duty% of cycles.
  task automatic collect(input bit sel, input int n, input int duty);
    int   got = 0;
    int   guard = 0;
    bit   held = 0;
    exp_t hv, e;
    logic v, l, ir;
    logic [15:0] d;
    logic [5:0]  c;
    hv = '0;
    while (got < n && guard < 3000) begin
      @(negedge clk);
      guard++;
      v  = sel ? out_valid_d : out_valid_a;
      d  = sel ? out_data_d  : out_data_a;
      l  = sel ? out_last_d  : out_last_a;
      c  = sel ? out_count_d : out_count_a;
      ir = sel ? in_ready_d  : in_ready_a;
      if (held) begin
        chk("stall_valid", 32'(v), 32'd1);
        chk("stall_data", 32'(d), 32'(hv.d));
        chk("stall_last", 32'(l), 32'(hv.l));
        chk("stall_count", 32'(c), 32'(hv.c));
      end
      if (v) chk("in_ready_in_drain", 32'(ir), 32'd0);
      out_ready = ($urandom_range(99) < duty);
      if (v && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(d), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(d), 32'(e.d));
          chk("out_last", 32'(l), 32'(e.l));
          chk("out_count", 32'(c), 32'(e.c));
        end
        got++;
        held = 0;
      end else if (v) begin
        held = 1;
        hv.d = d; hv.l = l; hv.c = c;
      end
    end
    if (got < n) chk("drain_timeout", 32'(got), 32'(n));
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // After a complete drain: nothing outstanding, input side reopened.
  task automatic check_idle(input bit sel);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("in_ready_after_frame", 32'(sel ? in_ready_d : in_ready_a), 32'd1);
    chk("out_valid_after_frame", 32'(sel ? out_valid_d : out_valid_a), 32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out_data", 32'(out_data_a), 32'd0);
    chk("rst_out_last", 32'(out_last_a), 32'd0);
    chk("rst_out_count", 32'(out_count_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_d_out_valid", 32'(out_valid_d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame 31..0 without in_last, plus latency
    frame.delete();
    for (int i = 31; i >= 0; i--) frame.push_back(16'(i));
    send_frame(0, 0);
    @(negedge clk);
    chk("lat_sort_valid", 32'(out_valid_a), 32'd0);
    chk("lat_sort_busy", 32'(busy_a), 32'd1);
    chk("lat_sort_in_ready", 32'(in_ready_a), 32'd0);
    @(negedge clk);
    chk("lat_first_valid", 32'(out_valid_a), 32'd1);
    collect(0, 32, 100);
    check_idle(0);

    // Short frame 5,3,9
    frame = '{16'd5, 16'd3, 16'd9};
    send_frame(0, 1);
    collect(0, 3, 100);
    check_idle(0);

    // Descending 1,4,2,4
    frame = '{16'd1, 16'd4, 16'd2, 16'd4};
    send_frame(1, 1);
    collect(1, 4, 100);
    check_idle(1);

    // Descending with genuine max key next to padding
    frame = '{16'hFFFF, 16'h0000};
    send_frame(1, 1);
    collect(1, 2, 100);
    check_idle(1);

    // Single-element frame
    frame = '{16'h1234};
    send_frame(0, 1);
    collect(0, 1, 100);
    check_idle(0);

    // FFFF,0,FFFF
    frame = '{16'hFFFF, 16'h0000, 16'hFFFF};
    send_frame(0, 1);
    collect(0, 3, 100);
    check_idle(0);

    // Backpressure, 30% ready, random keys
    frame.delete();
    for (int i = 0; i < 12; i++) frame.push_back(16'($urandom));
    send_frame(0, 1);
    collect(0, 12, 30);
    check_idle(0);

    // Reset during drain after 2 of 8 outputs
    frame = '{16'd80, 16'd10, 16'd70, 16'd20, 16'd60, 16'd30, 16'd50, 16'd40};
    send_frame(0, 1);
    collect(0, 2, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(out_valid_a), 32'd0);
    chk("rstmid_busy", 32'(busy_a), 32'd0);
    chk("rstmid_out_count", 32'(out_count_a), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_in_ready", 32'(in_ready_a), 32'd1);
    chk("rstmid_no_output", 32'(out_valid_a), 32'd0);
    frame = '{16'd7, 16'd2};
    send_frame(0, 1);
    collect(0, 2, 100);
    check_idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
